// File: rtl/ingress_pkg.sv
// Shared router definitions: FSM state encoding and the default word width
// common to ingress, egress serializer and port FIFO.
package router_pkg;
  localparam int WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;
endpackage

// File: rtl/ingress_if.sv
// Serial-port / FIFO-write bundle of one router input port.
interface ingress_if #(parameter int WIDTH = router_pkg::WIDTH);
  logic             din;
  logic             frame_n;
  logic             valid_n;
  logic             full;
  logic [WIDTH-1:0] dataout;
  logic             push;
  logic             frame_done;
  logic             frame_err;
  logic             overflow;
  logic             busy;

  modport master (
    output din, frame_n, valid_n, full,
    input  dataout, push, frame_done, frame_err, overflow, busy
  );

  modport slave (
    input  din, frame_n, valid_n, full,
    output dataout, push, frame_done, frame_err, overflow, busy
  );
endinterface

// File: rtl/ingress_sipo_shift.sv
// Serial-in/parallel-out register, LSB first. word shows the assembled word
// including the bit on the current edge, so it is valid alongside word_done.
module sipo_shift #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             din,
  input  logic             clr,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic             cnt_zero
);
  logic [WIDTH-1:0] shift_q;
  logic [CNTW-1:0]  count_q, count_d;
  logic             last;

  assign last = (count_q == CNTW'(WIDTH-1));

  always_comb begin
    count_d = count_q;
    if (clr)           count_d = '0;
    else if (shift_en) count_d = last ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (shift_en && !clr) shift_q[count_q] <= din;
    end
  end

  // Stale upper bits are harmless: every position is rewritten before word_done.
  always_comb begin
    word          = shift_q;
    word[count_q] = din;
  end

  assign word_done = shift_en & last & ~clr;
  assign cnt_zero  = (count_q == '0);
endmodule

// File: rtl/ingress.sv
// Receive side of a router port: deserializes framed serial words and pushes
// them into the input FIFO through a one-word holding register.
module ingress
  import router_pkg::*;
#(
  parameter int WIDTH = router_pkg::WIDTH,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     reset,
  ingress_if.slave port
);
  state_e           state_q, state_d;
  logic             shift_en, frame_end, cnt_zero, word_done;
  logic [WIDTH-1:0] word;
  logic             done_d, err_d;

  logic [WIDTH-1:0] pend_q, pend_d, dataout_q, dataout_d;
  logic             pend_vld_q, pend_vld_d;
  logic             push_q, push_d;
  logic             done_q, err_q, ovf_q, ovf_d;
  logic             accept;

  // Bits are accepted on the frame-opening edge too, so IDLE needs no extra cycle.
  assign shift_en  = ~port.frame_n & ~port.valid_n;
  assign frame_end = (state_q == RECV) & port.frame_n;

  sipo_shift #(.WIDTH(WIDTH), .CNTW(CNTW)) u_sipo (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .din       (port.din),
    .clr       (frame_end),
    .word      (word),
    .word_done (word_done),
    .cnt_zero  (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!port.frame_n) state_d = RECV;
      RECV:    if (port.frame_n)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_d = frame_end &  cnt_zero;
    err_d  = frame_end & ~cnt_zero;
  end

  // The holding slot frees on the same edge it drains, so a word completing
  // alongside a push is still kept.
  always_comb begin
    push_d     = pend_vld_q & ~port.full;
    accept     = push_d | ~pend_vld_q;
    dataout_d  = push_d ? pend_q : dataout_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q & ~push_d;
    ovf_d      = ovf_q;
    if (word_done) begin
      if (accept) begin
        pend_d     = word;
        pend_vld_d = 1'b1;
      end else begin
        ovf_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      dataout_q  <= '0;
      push_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      dataout_q  <= dataout_d;
      push_q     <= push_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign port.dataout    = dataout_q;
  assign port.push       = push_q;
  assign port.frame_done = done_q;
  assign port.frame_err  = err_q;
  assign port.overflow   = ovf_q;
  assign port.busy       = (state_q == RECV) | pend_vld_q;
endmodule

// File: tb/tb_ingress.sv
// Self-checking bench for ingress: directed table, hand-written corner
// sequences and a randomized run against a bit-stream reference model.
module tb_ingress;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ingress_if #(.WIDTH(32)) bus();
  ingress #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .port(bus));

  int checks = 0, errors = 0;

  // observed DUT activity
  logic [31:0] got_q[$];
  int          gdone, gerr;
  // reference model: bit accumulator, one-slot holding buffer, expected pushes
  logic [31:0] exp_q[$], mpend[$];
  logic [31:0] macc;
  int          mbits, mdone, merr;
  bit          min_frame, mover, rnd_full;

  typedef struct {
    logic [31:0] word;
    int          gap_a;
    int          gap_b;
    int          gaplen;
    int          full_hold;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.push)       got_q.push_back(bus.dataout);
      if (bus.frame_done) gdone++;
      if (bus.frame_err)  gerr++;
    end
  end

  task automatic model_reset();
    mpend.delete();
    mbits = 0; min_frame = 0; mover = 0;
  endtask

  task automatic clear_obs();
    got_q.delete(); exp_q.delete();
    gdone = 0; gerr = 0; mdone = 0; merr = 0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
      return;
    end
    if (mpend.size() > 0 && !bus.full) exp_q.push_back(mpend.pop_front());
    if (!bus.frame_n && !bus.valid_n) begin
      macc[mbits] = bus.din;
      mbits++;
      if (mbits == 32) begin
        mbits = 0;
        if (mpend.size() > 0) mover = 1;
        else                  mpend.push_back(macc);
      end
    end else if (min_frame && bus.frame_n) begin
      if (mbits == 0) mdone++;
      else            merr++;
      mbits = 0;
    end
    min_frame = !bus.frame_n;
  endtask

  task automatic tick();
    if (rnd_full) bus.full = ($urandom_range(0, 3) == 0);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    bus.frame_n = 1'b1; bus.valid_n = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_bits(input logic [63:0] data, input int nbits,
                           input int ga, input int gb, input int glen);
    for (int i = 0; i < nbits; i++) begin
      bus.frame_n = 1'b0; bus.valid_n = 1'b0; bus.din = data[i];
      tick();
      if (i == ga || i == gb)
        repeat (glen) begin
          bus.valid_n = 1'b1; bus.din = 1'($urandom_range(0, 1));
          tick();
        end
    end
  endtask

  task automatic end_frame();
    bus.frame_n = 1'b1; bus.valid_n = 1'b1;
    tick();
  endtask

  task automatic compare_model(input string tag);
    int n;
    chk({tag, "_push_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_push_data"}, got_q[i], exp_q[i]);
    chk({tag, "_frame_done"}, gdone, mdone);
    chk({tag, "_frame_err"}, gerr, merr);
    chk({tag, "_overflow"}, bus.overflow, mover);
  endtask

  initial begin
    logic bad;
    tbl[0] = '{32'hA5A5_0F0F, -1, -1, 0,  0, 32'hA5A5_0F0F};
    tbl[1] = '{32'hA5A5_0F0F,  7, 20, 3,  0, 32'hA5A5_0F0F};
    tbl[2] = '{32'hA5A5_0F0F, -1, -1, 0, 50, 32'hA5A5_0F0F};
    tbl[3] = '{32'h8000_0001,  0, 30, 2,  3, 32'h8000_0001};

    reset = 1'b1; rnd_full = 0;
    bus.din = 1'b0; bus.frame_n = 1'b1; bus.valid_n = 1'b1; bus.full = 1'b0;
    model_reset(); clear_obs();
    #12;
    chk("rst_dataout", bus.dataout, 0);
    chk("rst_push", bus.push, 0);
    chk("rst_flags", {bus.frame_done, bus.frame_err, bus.overflow, bus.busy}, 0);
    @(negedge clk); reset = 1'b0;
    idle(2);

    // exact push latency: last bit at edge N, push high only between N+1 and N+2
    clear_obs();
    send_bits(64'hA5A5_0F0F, 31, -1, -1, 0);
    bus.din = 1'b1; tick();
    chk("lat_no_push_at_N", bus.push, 0);
    end_frame();
    chk("lat_push_at_N1", bus.push, 1);
    chk("lat_data_at_N1", bus.dataout, 32'hA5A5_0F0F);
    chk("lat_done_pulse", bus.frame_done, 1);
    idle(1);
    chk("lat_push_low_N2", bus.push, 0);
    chk("lat_done_low", bus.frame_done, 0);
    idle(2);
    compare_model("lat");

    for (int t = 0; t < 4; t++) begin
      clear_obs();
      bus.full = (tbl[t].full_hold > 0);
      send_bits({32'h0, tbl[t].word}, 32, tbl[t].gap_a, tbl[t].gap_b, tbl[t].gaplen);
      end_frame();
      if (tbl[t].full_hold > 0) begin
        bad = 0;
        repeat (tbl[t].full_hold) begin
          tick();
          if (!bus.busy || bus.push) bad = 1;
        end
        chk("tbl_hold_busy_nopush", bad, 0);
        chk("tbl_hold_no_push_seen", got_q.size(), 0);
        bus.full = 1'b0;
        tick();
        chk("tbl_push_after_full", bus.push, 1);
      end
      idle(3);
      chk("tbl_push_count", got_q.size(), 1);
      if (got_q.size() > 0) chk("tbl_data", got_q[0], tbl[t].exp_data);
      chk("tbl_done", gdone, 1);
      chk("tbl_err", gerr, 0);
      compare_model("tbl");
    end

    // aborted short frame, then a clean word
    clear_obs();
    send_bits(64'h3FF, 10, -1, -1, 0);
    end_frame();
    idle(2);
    chk("err_pulses", gerr, 1);
    chk("err_no_push", got_q.size(), 0);
    send_bits(64'hFFFF_0000, 32, -1, -1, 0);
    end_frame();
    idle(3);
    chk("err_next_push_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("err_next_data", got_q[0], 32'hFFFF_0000);
    compare_model("err");

    // reset in the middle of a frame
    send_bits(64'hABC, 12, -1, -1, 0);
    #2 reset = 1'b1;
    bus.frame_n = 1'b1; bus.valid_n = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_outputs", {bus.push, bus.dataout}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    model_reset(); clear_obs();
    idle(1);
    send_bits(64'h1, 32, -1, -1, 0);
    end_frame();
    idle(3);
    chk("midrst_push_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("midrst_data", got_q[0], 1);
    chk("midrst_no_err", gerr, 0);
    compare_model("midrst");

    // two-word frame into a full FIFO: second word is dropped
    clear_obs();
    bus.full = 1'b1;
    send_bits({32'hDEAD_BEEF, 32'h1234_5678}, 64, -1, -1, 0);
    end_frame();
    idle(5);
    chk("ovf_no_push_while_full", got_q.size(), 0);
    bus.full = 1'b0;
    idle(3);
    chk("ovf_push_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("ovf_data", got_q[0], 32'h1234_5678);
    chk("ovf_flag", bus.overflow, 1);
    idle(10);
    chk("ovf_sticky", bus.overflow, 1);
    compare_model("ovf");

    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset(); clear_obs();
    chk("ovf_cleared_by_reset", bus.overflow, 0);

    // randomized back-to-back frames, gaps, partial frames and FIFO backpressure
    rnd_full = 1;
    for (int f = 0; f < 40; f++) begin
      int kind, nb;
      kind = $urandom_range(0, 3);
      nb = (kind < 2) ? 32 : (kind == 2) ? 64 : $urandom_range(1, 40);
      send_bits({$urandom, $urandom}, nb, $urandom_range(0, nb), $urandom_range(0, nb),
                $urandom_range(0, 3));
      end_frame();
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    rnd_full = 0; bus.full = 1'b0;
    idle(4);
    compare_model("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
